// File: rtl/lsu_mem_access.sv
// Load/store access unit for the RV32 memory stage.
// Accepts one op at a time, runs a single req/gnt/rvalid data-bus access,
// then presents the aligned and extended result (or an error) to writeback.
//
// Handshakes: on every interface a transfer happens on the clock edge where
// valid (or req) and ready (or gnt) are both high. A producer holds valid
// and its payload stable until that edge and does not withdraw it early.
// rvalid is a single-cycle response and is only honoured while waiting.
module lsu_mem_access #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  load_store_i_info,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_misalign,
    output logic        out_timeout,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_wstrb,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [7:0] LP_TMO = 8'(TIMEOUT_CYC);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_info;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_misalign;
    logic        r_timeout;
    logic [7:0]  r_cnt;

    logic        w_accept;
    logic        w_in_onehot;
    logic        w_in_half;
    logic        w_in_word;
    logic        w_in_misalign;
    logic        w_in_skip_bus;
    logic        w_r_is_store;
    logic [7:0]  w_cnt_inc;
    logic        w_tmo_hit;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load_data;
    logic [3:0]  w_st_wstrb;
    logic [31:0] w_st_wdata;

    // Decode of the incoming op; only a single-hot info vector is a real access.
    assign w_accept      = in_valid && (r_state == S_IDLE);
    assign w_in_onehot   = (load_store_i_info != 8'd0) &&
                           ((load_store_i_info & (load_store_i_info - 8'd1)) == 8'd0);
    assign w_in_half     = load_store_i_info[1] | load_store_i_info[4] | load_store_i_info[6];
    assign w_in_word     = load_store_i_info[2] | load_store_i_info[7];
    assign w_in_misalign = w_in_onehot &&
                           ((w_in_half && mem_addr[0]) ||
                            (w_in_word && (mem_addr[1:0] != 2'b00)));
    assign w_in_skip_bus = !w_in_onehot || w_in_misalign;

    assign w_r_is_store  = |r_info[7:5];
    assign w_cnt_inc     = r_cnt + 8'd1;
    assign w_tmo_hit     = (w_cnt_inc == LP_TMO);
    assign o_dbg_state   = r_state;

    // Pick the addressed byte and halfword out of the returned bus word.
    always_comb begin
        w_lane_byte = 8'd0;
        case (r_addr[1:0])
            2'd0:    w_lane_byte = dbus_rdata[7:0];
            2'd1:    w_lane_byte = dbus_rdata[15:8];
            2'd2:    w_lane_byte = dbus_rdata[23:16];
            default: w_lane_byte = dbus_rdata[31:24];
        endcase
        w_lane_half = r_addr[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    end

    // Sign or zero extend the selected lane according to the load type.
    always_comb begin
        w_load_data = 32'd0;
        if (r_info[0]) begin
            w_load_data = {{24{w_lane_byte[7]}}, w_lane_byte};
        end else if (r_info[1]) begin
            w_load_data = {{16{w_lane_half[15]}}, w_lane_half};
        end else if (r_info[2]) begin
            w_load_data = dbus_rdata;
        end else if (r_info[3]) begin
            w_load_data = {24'd0, w_lane_byte};
        end else if (r_info[4]) begin
            w_load_data = {16'd0, w_lane_half};
        end
    end

    // Replicate store data into every lane and enable only the addressed bytes.
    always_comb begin
        w_st_wstrb = 4'b0000;
        w_st_wdata = 32'd0;
        if (r_info[5]) begin
            w_st_wstrb = 4'b0001 << r_addr[1:0];
            w_st_wdata = {4{r_wdata[7:0]}};
        end else if (r_info[6]) begin
            w_st_wstrb = 4'b0011 << r_addr[1:0];
            w_st_wdata = {2{r_wdata[15:0]}};
        end else if (r_info[7]) begin
            w_st_wstrb = 4'hF;
            w_st_wdata = r_wdata;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and all registered-state-driven outputs.
    always_comb begin
        w_state_nxt  = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_rdata    = 32'd0;
        out_misalign = 1'b0;
        out_timeout  = 1'b0;
        dbus_req     = 1'b0;
        dbus_we      = 1'b0;
        dbus_addr    = 32'd0;
        dbus_wdata   = 32'd0;
        dbus_wstrb   = 4'd0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = w_in_skip_bus ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                dbus_req   = 1'b1;
                dbus_we    = w_r_is_store;
                dbus_addr  = {r_addr[31:2], 2'b00};
                dbus_wdata = w_st_wdata;
                dbus_wstrb = w_st_wstrb;
                if (dbus_gnt) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dbus_rvalid || w_tmo_hit) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                out_valid    = 1'b1;
                out_rdata    = r_rdata;
                out_misalign = r_misalign;
                out_timeout  = r_timeout;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Op capture, wait counter and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_info     <= 8'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
            r_cnt      <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_info     <= load_store_i_info;
                        r_addr     <= mem_addr;
                        r_wdata    <= mem_wdata;
                        r_misalign <= w_in_misalign;
                        r_timeout  <= 1'b0;
                        r_rdata    <= 32'd0;
                    end
                end
                S_REQ: begin
                    if (dbus_gnt) begin
                        r_cnt <= 8'd0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    // A response in the timeout cycle still counts as a response.
                    if (dbus_rvalid) begin
                        r_rdata <= w_r_is_store ? 32'd0 : w_load_data;
                    end else if (w_tmo_hit) begin
                        r_timeout <= 1'b1;
                        r_rdata   <= 32'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access with a 4-cycle bus timeout.
module tb_lsu_mem_access;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  load_store_i_info;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_misalign;
    logic        out_timeout;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_wstrb;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic [1:0]  o_dbg_state;

    int n_cmp;
    int n_bad;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    lsu_mem_access #(.TIMEOUT_CYC(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .load_store_i_info (load_store_i_info),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_rdata         (out_rdata),
        .out_misalign      (out_misalign),
        .out_timeout       (out_timeout),
        .dbus_req          (dbus_req),
        .dbus_we           (dbus_we),
        .dbus_addr         (dbus_addr),
        .dbus_wdata        (dbus_wdata),
        .dbus_wstrb        (dbus_wstrb),
        .dbus_gnt          (dbus_gnt),
        .dbus_rvalid       (dbus_rvalid),
        .dbus_rdata        (dbus_rdata),
        .o_dbg_state       (o_dbg_state)
    );

    // Clock and global time limit.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single cycle; the DUT is idle so it is taken at once.
    task automatic issue(input logic [7:0] info, input logic [31:0] addr, input logic [31:0] wdata);
        in_valid          = 1'b1;
        load_store_i_info = info;
        mem_addr          = addr;
        mem_wdata         = wdata;
        step();
        in_valid          = 1'b0;
        load_store_i_info = 8'd0;
        mem_addr          = 32'd0;
        mem_wdata         = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++; if (o_dbg_state !== ST_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", o_dbg_state, ST_IDLE); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if ({out_valid, out_misalign, out_timeout, dbus_req, dbus_we} !== 5'd0) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {out_valid, out_misalign, out_timeout, dbus_req, dbus_we}); end
        n_cmp++; if ({out_rdata, dbus_addr, dbus_wdata, dbus_wstrb} !== 100'd0) begin n_bad++; $display("FAIL reset_buses: rdata %h addr %h wdata %h wstrb %h want all 0", out_rdata, dbus_addr, dbus_wdata, dbus_wstrb); end
        rst_n = 1'b1;
        step();
    endtask

    // Load with gnt and rvalid each one cycle after being awaited, out_ready high.
    task automatic do_load(input string nm, input logic [7:0] info, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_addr, input logic [31:0] exp_data);
        issue(info, addr, 32'hA5A5_A5A5);
        n_cmp++; if (dbus_req !== 1'b1 || dbus_we !== 1'b0) begin n_bad++; $display("FAIL %s_req: req %b we %b want 1 0", nm, dbus_req, dbus_we); end
        n_cmp++; if (dbus_addr !== exp_addr) begin n_bad++; $display("FAIL %s_addr: got %h want %h", nm, dbus_addr, exp_addr); end
        n_cmp++; if (dbus_wstrb !== 4'd0) begin n_bad++; $display("FAIL %s_wstrb: got %b want 0000", nm, dbus_wstrb); end
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL %s_c1: out_valid %b in_ready %b want 0 0", nm, out_valid, in_ready); end
        dbus_gnt = 1'b1;
        step();
        dbus_gnt = 1'b0;
        n_cmp++; if (dbus_req !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_c2: req %b out_valid %b want 0 0", nm, dbus_req, out_valid); end
        dbus_rvalid = 1'b1;
        dbus_rdata  = rdata;
        step();
        dbus_rvalid = 1'b0;
        dbus_rdata  = 32'd0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL %s_latency: out_valid %b want 1 three cycles after accept", nm, out_valid); end
        n_cmp++; if (out_rdata !== exp_data) begin n_bad++; $display("FAIL %s_data: got %h want %h", nm, out_rdata, exp_data); end
        n_cmp++; if (out_misalign !== 1'b0 || out_timeout !== 1'b0) begin n_bad++; $display("FAIL %s_flags: mis %b tmo %b want 0 0", nm, out_misalign, out_timeout); end
        step();
        n_cmp++; if (o_dbg_state !== ST_IDLE || out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_done: state %0d out_valid %b want 0 0", nm, o_dbg_state, out_valid); end
    endtask

    // Store with gnt held off for gnt_dly cycles to check that the request stays put.
    task automatic do_store(input string nm, input logic [7:0] info, input logic [31:0] addr, input logic [31:0] wdata,
                            input int gnt_dly, input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        issue(info, addr, wdata);
        for (int i = 0; i <= gnt_dly; i++) begin
            n_cmp++; if (dbus_req !== 1'b1 || dbus_we !== 1'b1) begin n_bad++; $display("FAIL %s_req%0d: req %b we %b want 1 1", nm, i, dbus_req, dbus_we); end
            n_cmp++; if (dbus_addr !== {addr[31:2], 2'b00}) begin n_bad++; $display("FAIL %s_addr%0d: got %h want %h", nm, i, dbus_addr, {addr[31:2], 2'b00}); end
            n_cmp++; if (dbus_wstrb !== exp_strb) begin n_bad++; $display("FAIL %s_wstrb%0d: got %b want %b", nm, i, dbus_wstrb, exp_strb); end
            n_cmp++; if (dbus_wdata !== exp_wdata) begin n_bad++; $display("FAIL %s_wdata%0d: got %h want %h", nm, i, dbus_wdata, exp_wdata); end
            if (i == gnt_dly) dbus_gnt = 1'b1;
            step();
        end
        dbus_gnt = 1'b0;
        n_cmp++; if (dbus_req !== 1'b0 || o_dbg_state !== ST_WAIT) begin n_bad++; $display("FAIL %s_wait: req %b state %0d want 0 2", nm, dbus_req, o_dbg_state); end
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'hFFFF_FFFF;
        step();
        dbus_rvalid = 1'b0;
        dbus_rdata  = 32'd0;
        n_cmp++; if (out_valid !== 1'b1 || out_rdata !== 32'd0) begin n_bad++; $display("FAIL %s_resp: valid %b rdata %h want 1 00000000", nm, out_valid, out_rdata); end
        n_cmp++; if (out_misalign !== 1'b0 || out_timeout !== 1'b0) begin n_bad++; $display("FAIL %s_flags: mis %b tmo %b want 0 0", nm, out_misalign, out_timeout); end
        step();
    endtask

    // Ops that never reach the bus: result appears the cycle after accept.
    task automatic do_nobus(input string nm, input logic [7:0] info, input logic [31:0] addr, input logic exp_mis);
        issue(info, addr, 32'h1234_5678);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL %s_valid: got %b want 1", nm, out_valid); end
        n_cmp++; if (dbus_req !== 1'b0) begin n_bad++; $display("FAIL %s_noreq: got %b want 0", nm, dbus_req); end
        n_cmp++; if (out_misalign !== exp_mis || out_timeout !== 1'b0) begin n_bad++; $display("FAIL %s_flags: mis %b tmo %b want %b 0", nm, out_misalign, out_timeout, exp_mis); end
        n_cmp++; if (out_rdata !== 32'd0) begin n_bad++; $display("FAIL %s_rdata: got %h want 00000000", nm, out_rdata); end
        step();
        n_cmp++; if (o_dbg_state !== ST_IDLE || dbus_req !== 1'b0) begin n_bad++; $display("FAIL %s_done: state %0d req %b want 0 0", nm, o_dbg_state, dbus_req); end
    endtask

    task automatic test_lw();
        do_load("lw", 8'h04, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_1000, 32'hDEAD_BEEF);
    endtask

    task automatic test_load_extend();
        do_load("lb",  8'h01, 32'h0000_1003, 32'h80FF_0011, 32'h0000_1000, 32'hFFFF_FF80);
        do_load("lbu", 8'h08, 32'h0000_1003, 32'h80FF_0011, 32'h0000_1000, 32'h0000_0080);
        do_load("lh",  8'h02, 32'h0000_1002, 32'h80FF_0011, 32'h0000_1000, 32'hFFFF_80FF);
        do_load("lhu", 8'h10, 32'h0000_1002, 32'h80FF_0011, 32'h0000_1000, 32'h0000_80FF);
        do_load("lb0", 8'h01, 32'h0000_1000, 32'h80FF_0011, 32'h0000_1000, 32'h0000_0011);
        do_load("lb1", 8'h01, 32'h0000_1001, 32'h80FF_0011, 32'h0000_1000, 32'h0000_0000);
        do_load("lh0", 8'h02, 32'h0000_1000, 32'h1234_8001, 32'h0000_1000, 32'hFFFF_8001);
    endtask

    task automatic test_store();
        do_store("sb", 8'h20, 32'h0000_2001, 32'h1234_5678, 0, 4'b0010, 32'h7878_7878);
        do_store("sh", 8'h40, 32'h0000_2002, 32'h1234_5678, 2, 4'b1100, 32'h5678_5678);
        do_store("sw", 8'h80, 32'h0000_2004, 32'h1234_5678, 1, 4'b1111, 32'h1234_5678);
        do_store("sb3", 8'h20, 32'h0000_2003, 32'hCAFE_00AB, 0, 4'b1000, 32'hABAB_ABAB);
    endtask

    task automatic test_misalign();
        do_nobus("lh_mis",  8'h02, 32'h0000_3001, 1'b1);
        do_nobus("lw_mis",  8'h04, 32'h0000_3002, 1'b1);
        do_nobus("sh_mis",  8'h40, 32'h0000_3003, 1'b1);
        do_nobus("sw_mis",  8'h80, 32'h0000_3001, 1'b1);
    endtask

    task automatic test_nonmem();
        do_nobus("nop",      8'h00, 32'h0000_6000, 1'b0);
        do_nobus("multihot", 8'h05, 32'h0000_6001, 1'b0);
        do_nobus("multist",  8'hC0, 32'h0000_6002, 1'b0);
    endtask

    task automatic test_timeout();
        // No response at all: four WAIT cycles, then a timeout result.
        issue(8'h04, 32'h0000_4000, 32'd0);
        n_cmp++; if (dbus_req !== 1'b1) begin n_bad++; $display("FAIL tmo_req: got %b want 1", dbus_req); end
        dbus_gnt = 1'b1;
        step();
        dbus_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (o_dbg_state !== ST_WAIT || out_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_wait%0d: state %0d valid %b want 2 0", i, o_dbg_state, out_valid); end
            step();
        end
        n_cmp++; if (out_valid !== 1'b1 || out_timeout !== 1'b1) begin n_bad++; $display("FAIL tmo_flag: valid %b tmo %b want 1 1", out_valid, out_timeout); end
        n_cmp++; if (out_rdata !== 32'd0 || out_misalign !== 1'b0) begin n_bad++; $display("FAIL tmo_rdata: rdata %h mis %b want 00000000 0", out_rdata, out_misalign); end
        step();
        // Response lands in the timeout cycle: the data wins.
        issue(8'h04, 32'h0000_4004, 32'd0);
        dbus_gnt = 1'b1;
        step();
        dbus_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (o_dbg_state !== ST_WAIT) begin n_bad++; $display("FAIL tmo_race_wait%0d: state %0d want 2", i, o_dbg_state); end
            if (i == 3) begin
                dbus_rvalid = 1'b1;
                dbus_rdata  = 32'hCAFE_F00D;
            end
            step();
        end
        dbus_rvalid = 1'b0;
        dbus_rdata  = 32'd0;
        n_cmp++; if (out_valid !== 1'b1 || out_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_race_flag: valid %b tmo %b want 1 0", out_valid, out_timeout); end
        n_cmp++; if (out_rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL tmo_race_data: got %h want cafef00d", out_rdata); end
        step();
    endtask

    task automatic test_backpressure_reset();
        out_ready = 1'b0;
        issue(8'h04, 32'h0000_5004, 32'd0);
        dbus_gnt = 1'b1;
        step();
        dbus_gnt = 1'b0;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h0BAD_F00D;
        step();
        dbus_rvalid = 1'b0;
        dbus_rdata  = 32'd0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || o_dbg_state !== ST_RESP) begin n_bad++; $display("FAIL bp_hold%0d: valid %b state %0d want 1 3", i, out_valid, o_dbg_state); end
            n_cmp++; if (out_rdata !== 32'h0BAD_F00D || in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_data%0d: rdata %h in_ready %b want 0badf00d 0", i, out_rdata, in_ready); end
            step();
        end
        out_ready = 1'b1;
        step();
        n_cmp++; if (o_dbg_state !== ST_IDLE) begin n_bad++; $display("FAIL bp_release: state %0d want 0", o_dbg_state); end
        // Second load, reset while waiting for the response.
        issue(8'h04, 32'h0000_5008, 32'd0);
        dbus_gnt = 1'b1;
        step();
        dbus_gnt = 1'b0;
        n_cmp++; if (o_dbg_state !== ST_WAIT) begin n_bad++; $display("FAIL rst_pre: state %0d want 2", o_dbg_state); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++; if (o_dbg_state !== ST_IDLE || in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_state: state %0d in_ready %b want 0 1", o_dbg_state, in_ready); end
        n_cmp++; if ({out_valid, out_misalign, out_timeout, dbus_req, dbus_we, dbus_wstrb} !== 9'd0 || out_rdata !== 32'd0 || dbus_addr !== 32'd0) begin n_bad++; $display("FAIL rst_mid_outs: valid %b rdata %h req %b addr %h want all 0", out_valid, out_rdata, dbus_req, dbus_addr); end
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'hFFFF_FFFF;
        step();
        dbus_rvalid = 1'b0;
        dbus_rdata  = 32'd0;
        n_cmp++; if (o_dbg_state !== ST_IDLE || out_valid !== 1'b0 || out_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_late_rvalid: state %0d valid %b rdata %h want 0 0 0", o_dbg_state, out_valid, out_rdata); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || dbus_req !== 1'b0) begin n_bad++; $display("FAIL rst_settle: valid %b req %b want 0 0", out_valid, dbus_req); end
    endtask

    initial begin
        n_cmp             = 0;
        n_bad             = 0;
        rst_n             = 1'b0;
        in_valid          = 1'b0;
        load_store_i_info = 8'd0;
        mem_addr          = 32'd0;
        mem_wdata         = 32'd0;
        out_ready         = 1'b1;
        dbus_gnt          = 1'b0;
        dbus_rvalid       = 1'b0;
        dbus_rdata        = 32'd0;
        test_reset();
        test_lw();
        test_load_extend();
        test_store();
        test_misalign();
        test_nonmem();
        test_timeout();
        test_backpressure_reset();
        test_lw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
